// File: rtl/water_sensor_frontend.sv
// rtl/water_sensor_frontend.sv - serial moisture sensor reader and tank probe debouncer (optional averaging: WATER_AVG_EN)
module water_sensor_frontend #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       sample_tick,
    input  logic       sdata,
    input  logic       probe_low,
    input  logic       probe_high,
    output logic       cs_n,
    output logic       sclk_out,
    output logic [7:0] Moisture_sensor,
    output logic [1:0] Water_sensor,
    output logic       data_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       level_fault
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [8:0]  sh_q, sh_d;
    logic [7:0]  moist_q, moist_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  new_byte;

    logic [1:0]       raw;
    logic [1:0]       deb_q, deb_d;
    logic [1:0][3:0]  dcnt_q, dcnt_d;

`ifdef WATER_AVG_EN
    // three previous good bytes; the fourth term of the average is the byte just received
    logic [7:0] h0_q, h1_q, h2_q;
    logic [9:0] sum;
    assign sum      = {2'b00, sh_q[7:0]} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
    assign new_byte = sum[9:2];

    // history shifts only on good frames
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            h0_q <= 8'd0;
            h1_q <= 8'd0;
            h2_q <= 8'd0;
        end else if (valid_d) begin
            h0_q <= sh_q[7:0];
            h1_q <= h0_q;
            h2_q <= h1_q;
        end
    end
`else
    assign new_byte = sh_q[7:0];
`endif

    // frame FSM: capture on odd SHIFT cycles, judge start/stop bits at the last one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        moist_d = moist_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = SHIFT;
                    cnt_d   = 5'd0;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd19) begin
                    state_d = DONE;
                    if (!sh_q[8] && sdata) begin
                        valid_d = 1'b1;
                        moist_d = new_byte;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q[0]) begin
                    sh_d = {sh_q[7:0], sdata};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // frame state and result registers
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            sh_q    <= 9'd0;
            moist_q <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            moist_q <= moist_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign raw = {probe_high, probe_low};

    // per-probe debounce: count consecutive disagreeing cycles, any agreement restarts
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (raw[i] != deb_q[i]) begin
                if (dcnt_q[i] == 4'(DEB_CYCLES - 1)) begin
                    deb_d[i]  = raw[i];
                    dcnt_d[i] = 4'd0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 4'd1;
                end
            end else begin
                dcnt_d[i] = 4'd0;
            end
        end
    end

    // debounce registers
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            deb_q  <= 2'b00;
            dcnt_q <= '0;
        end else begin
            deb_q  <= deb_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign cs_n            = (state_q != SHIFT);
    assign busy            = (state_q == SHIFT);
    assign sclk_out        = (state_q == SHIFT) && cnt_q[0];
    assign Moisture_sensor = moist_q;
    assign data_valid      = valid_q;
    assign frame_err       = err_q;
    assign Water_sensor    = deb_q;
    assign level_fault     = deb_q[1] && !deb_q[0];

endmodule

// File: tb/tb_water_sensor_frontend.sv
// tb/tb_water_sensor_frontend.sv - table-driven bench for water_sensor_frontend
module tb_water_sensor_frontend;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       sample_tick = 1'b0;
    logic       sdata = 1'b1;
    logic       probe_low = 1'b0;
    logic       probe_high = 1'b0;
    logic       cs_n, sclk_out, data_valid, busy, frame_err, level_fault;
    logic [7:0] Moisture_sensor;
    logic [1:0] Water_sensor;

    int checks = 0;
    int errors = 0;

    water_sensor_frontend #(.DEB_CYCLES(4)) dut (
        .CLK(CLK), .Reset(Reset), .sample_tick(sample_tick), .sdata(sdata),
        .probe_low(probe_low), .probe_high(probe_high), .cs_n(cs_n),
        .sclk_out(sclk_out), .Moisture_sensor(Moisture_sensor),
        .Water_sensor(Water_sensor), .data_valid(data_valid), .busy(busy),
        .frame_err(frame_err), .level_fault(level_fault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         do_reset;
        logic [7:0] data;
        logic       start_b;
        logic       stop_b;
        bit         retick;
        logic       exp_v;
        logic       exp_e;
        logic [7:0] exp_raw;
        logic [7:0] exp_avg;
    } frame_vec_t;

    frame_vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset_seq();
        @(negedge CLK);
        Reset = 1'b0;
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sclk", sclk_out, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_moist", Moisture_sensor, 0);
        chk("rst_water", Water_sensor, 0);
        chk("rst_fault", level_fault, 0);
        Reset = 1'b1;
        @(negedge CLK);
        chk("tick_in_reset_ignored", busy, 0);
    endtask

    task automatic run_frame(input frame_vec_t v);
        logic [7:0] exp_m;
        logic       b;
        int         k;
`ifdef WATER_AVG_EN
        exp_m = v.exp_avg;
`else
        exp_m = v.exp_raw;
`endif
        @(negedge CLK);
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        for (int n = 0; n < 20; n++) begin
            chk("shift_cs_n", cs_n, 0);
            chk("shift_busy", busy, 1);
            chk("shift_sclk", sclk_out, n % 2);
            chk("shift_no_pulse", {data_valid, frame_err}, 0);
            sample_tick = (v.retick && n == 4);
            if (n % 2 == 1) begin
                k = (n - 1) / 2;
                if (k == 0)      b = v.start_b;
                else if (k == 9) b = v.stop_b;
                else             b = v.data[8 - k];
                sdata = b;
            end else begin
                sdata = 1'($urandom_range(0, 1));
            end
            @(negedge CLK);
        end
        sample_tick = 1'b0;
        sdata = 1'b1;
        chk("done_dv", data_valid, v.exp_v);
        chk("done_ferr", frame_err, v.exp_e);
        chk("done_moist", Moisture_sensor, exp_m);
        chk("done_cs_n", cs_n, 1);
        chk("done_busy", busy, 0);
        @(negedge CLK);
        chk("after_pulse", {data_valid, frame_err}, 0);
        chk("after_busy", busy, 0);
        chk("after_moist", Moisture_sensor, exp_m);
        repeat (3) begin
            @(negedge CLK);
            chk("idle_quiet", {busy, data_valid, frame_err}, 0);
        end
    endtask

    task automatic set_probes(input logic [1:0] p);
        probe_high = p[1];
        probe_low  = p[0];
    endtask

    initial begin
        //            rst data   st  sp  rt  v  e  raw    avg
        vecs[0]  = '{1, 8'h20, 0, 1, 0, 1, 0, 8'h20, 8'h08};
        vecs[1]  = '{0, 8'h55, 0, 0, 0, 0, 1, 8'h20, 8'h08};
        vecs[2]  = '{0, 8'hA0, 1, 1, 0, 0, 1, 8'h20, 8'h08};
        vecs[3]  = '{0, 8'hA0, 0, 1, 0, 1, 0, 8'hA0, 8'h30};
        vecs[4]  = '{0, 8'hA0, 0, 1, 0, 1, 0, 8'hA0, 8'h58};
        vecs[5]  = '{0, 8'hA0, 0, 1, 0, 1, 0, 8'hA0, 8'h80};
        vecs[6]  = '{0, 8'hA0, 0, 1, 0, 1, 0, 8'hA0, 8'hA0};
        vecs[7]  = '{0, 8'hFF, 0, 1, 0, 1, 0, 8'hFF, 8'hB7};
        vecs[8]  = '{0, 8'h01, 0, 1, 1, 1, 0, 8'h01, 8'h90};
        vecs[9]  = '{1, 8'hA0, 0, 1, 0, 1, 0, 8'hA0, 8'h28};
        vecs[10] = '{0, 8'hA0, 0, 1, 1, 1, 0, 8'hA0, 8'h50};
        vecs[11] = '{0, 8'hA0, 0, 1, 0, 1, 0, 8'hA0, 8'h78};
        vecs[12] = '{0, 8'hA0, 0, 1, 0, 1, 0, 8'hA0, 8'hA0};

        repeat (2) @(negedge CLK);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_reset) do_reset_seq();
            run_frame(vecs[i]);
        end

        // reset mid-frame aborts it
        do_reset_seq();
        sample_tick = 1'b1;
        @(negedge CLK);
        sample_tick = 1'b0;
        repeat (9) @(negedge CLK);
        chk("mid_busy_before", busy, 1);
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        chk("mid_cs_n", cs_n, 1);
        chk("mid_busy", busy, 0);
        for (int c = 0; c < 15; c++) begin
            chk("mid_no_pulse", {data_valid, frame_err}, 0);
            @(negedge CLK);
        end
        chk("mid_moist", Moisture_sensor, 0);

        // debounce: 3-cycle glitch filtered, 4-cycle hold accepted
        set_probes(2'b01);
        repeat (3) @(negedge CLK);
        chk("deb_3_still_00", Water_sensor, 2'b00);
        set_probes(2'b00);
        repeat (5) begin
            @(negedge CLK);
            chk("deb_glitch_00", Water_sensor, 2'b00);
        end
        set_probes(2'b01);
        repeat (3) @(negedge CLK);
        chk("deb_3of4_00", Water_sensor, 2'b00);
        @(negedge CLK);
        chk("deb_4_01", Water_sensor, 2'b01);
        chk("deb_01_fault", level_fault, 0);
        set_probes(2'b10);
        repeat (4) @(negedge CLK);
        chk("deb_10", Water_sensor, 2'b10);
        chk("deb_10_fault", level_fault, 1);
        set_probes(2'b11);
        repeat (4) @(negedge CLK);
        chk("deb_11", Water_sensor, 2'b11);
        chk("deb_11_fault", level_fault, 0);

        // debouncers restart from 00 after reset
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("deb_rst_00", Water_sensor, 2'b00);
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        chk("deb_post_rst_3", Water_sensor, 2'b00);
        @(negedge CLK);
        chk("deb_post_rst_4", Water_sensor, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/water_sensor_frontend.md
WATER_SENSOR_FRONTEND -- requirements
Module: water_sensor_frontend

Interface
REQ-001 Parameter: DEB_CYCLES, 4, consecutive stable cycles before a debounced tank probe changes value (range 2..15).
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
REQ-004 sample_tick  input  1  one-cycle request to start a moisture conversion.
REQ-005 sdata  input  1  serial data from the moisture sensor.
REQ-006 probe_low, probe_high  input  1 each  raw tank float probes, 1 = wet.
REQ-007 cs_n  output  1  sensor chip select, active low.
REQ-008 sclk_out  output  1  serial clock to the sensor.
REQ-009 Moisture_sensor  output  8  latest moisture byte, feeds the water controller.
REQ-010 Water_sensor  output  2  debounced tank level {probe_high, probe_low}, feeds the water controller.
REQ-011 data_valid  output  1  one-cycle pulse when Moisture_sensor updates.
REQ-012 busy, frame_err, level_fault  output  1 each  frame in progress; one-cycle bad-frame pulse; probe inconsistency.

Function
REQ-013 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on sample_tick, SHIFT->DONE after 20 cycles, DONE->IDLE after 1 cycle.
REQ-014 sample_tick accepted at cycle T: cs_n=0 and busy=1 for cycles T+1..T+20; data_valid or frame_err pulses at T+21.
REQ-015 sample_tick while busy=1 or in DONE is ignored, not queued.
REQ-016 In SHIFT, sclk_out=0 on even cycle index n (0..19) and 1 on odd n; sclk_out=0 outside SHIFT.
REQ-017 Frame bit k (0..9) is sdata sampled at end of SHIFT cycle 2k+1: bit 0 start (must be 0), bits 1..8 data MSB first, bit 9 stop (must be 1).
REQ-018 Good frame: in DONE, Moisture_sensor updated per REQ-027/028 and data_valid=1.
REQ-019 Bad start or stop bit: frame_err=1 in DONE, Moisture_sensor and history unchanged, data_valid=0.
REQ-020 Each raw probe has its own debouncer: debounced value changes only after the raw input differs from it for DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
REQ-021 Water_sensor updates continuously, independent of the FSM: 00 empty, 01 mid, 11 full.
REQ-022 Debounced 10 (high wet, low dry) drives Water_sensor=10 and level_fault=1; otherwise level_fault=0.

Reset
REQ-023 Reset=0 at a rising edge: FSM->IDLE, cs_n=1, sclk_out=0, busy=0, data_valid=0, frame_err=0, Moisture_sensor=0, Water_sensor=00, level_fault=0, debounce counters and averaging history cleared.
REQ-024 Reset mid-frame aborts the frame: no data_valid or frame_err for that frame; cs_n=1 on the following cycle.
REQ-025 sample_tick during the Reset cycle is ignored.
REQ-026 Debouncers restart from 00 after reset; raw probes at 11 give Water_sensor=11 exactly DEB_CYCLES cycles after reset release.

Configuration
REQ-027 With WATER_AVG_EN defined, Moisture_sensor = (sum of last 4 good bytes) >> 2, using a 10-bit sum with truncation; the 4-entry history is zero after reset, so the first byte 0xA0 gives 0x28.
REQ-028 Without WATER_AVG_EN, Moisture_sensor = the raw byte of the latest good frame; no history storage is synthesized.

Verification
REQ-029 Reset, then sample_tick with serial frame 0,00100000,1 -> cs_n low 20 cycles, data_valid at T+21, Moisture_sensor=0x20 (0x08 with WATER_AVG_EN).
REQ-030 Frame with stop bit 0 after a good 0x20 frame -> frame_err pulse, data_valid=0, Moisture_sensor remains 0x20 (or its averaged value).
REQ-031 With WATER_AVG_EN: good frames 0xA0, 0xA0, 0xA0, 0xA0 -> outputs 0x28, 0x50, 0x78, 0xA0.
REQ-032 Probes raw 01 held 3 cycles then 00 -> Water_sensor stays 00; held 4 cycles -> 01; raw 10 stable -> Water_sensor=10, level_fault=1; raw 11 -> 11, level_fault=0.
REQ-033 sample_tick re-asserted at T+5 during a frame -> ignored, exactly one result pulse at T+21.
REQ-034 Reset=0 at T+10 mid-frame -> cs_n=1 at T+11, no result pulse, Moisture_sensor=0.
